sram_timing_ctrl: RTL and testbench

Parametrised asynchronous-SRAM controller succeeding the fixed-timing RAM path of the physical memory controller. It accepts word reads and byte-enabled writes from the CPU memory stage, posts writes into a FIFO write buffer so the CPU does not stall, and drains them to the SRAM with programmable write-pulse and recovery timing. Read wait states are configurable. Read-after-write hazards against buffered writes are resolved inside the block.

---
 rtl/sram_timing_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_sram_timing_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_timing_ctrl.sv
// Asynchronous SRAM controller with a posted-write FIFO, programmable write pulse/recovery and read wait states.
// Latency: read rsp_valid at accept+READ_WAIT+2 (forwarded hit: accept+1); writes post in 0 cycles, drain WE_WIDTH+RECOVERY+1 per entry.
// Backpressure: writes stall only on a full buffer; reads stall outside IDLE or on a buffered-write hazard.
//
// Optional feature macro: SRAMCTL_RD_FWD_EN (read forwarding from the write buffer / hazard compare).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    CPU request (valid/ready), write carries byte enables + data
//   rsp_valid, rsp_rdata     one-cycle read-data pulse; data held until the next pulse
//   wbuf_count               number of buffered writes
//   sram_*                   registered SRAM address, strobes (active-low), bidirectional data
module sram_timing_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_WIDTH   = 1,
    parameter int RECOVERY   = 1,
    parameter int READ_WAIT  = 0,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [BE_W-1:0]               req_be,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          req_ready,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   wbuf_count,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    inout  wire  [DATA_WIDTH-1:0]         sram_data,
    output logic                          sram_ce_n,
    output logic                          sram_oe_n,
    output logic                          sram_we_n,
    output logic [BE_W-1:0]               sram_be_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       WE_LAST  = 4'(WE_WIDTH - 1);
    localparam logic [3:0]       REC_LAST = 4'((RECOVERY > 0) ? RECOVERY - 1 : 0);
    localparam logic [3:0]       RD_LAST  = 4'(READ_WAIT);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_PULSE, WR_RECOV} state_t;

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;

    // Write buffer storage
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [BE_W-1:0]       fifo_be   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    // Entry currently being written to the SRAM
    logic [BE_W-1:0]       wr_be, wr_be_d;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  drv_en, drv_en_d;

    logic                  ce_n_d, oe_n_d, we_n_d;
    logic [BE_W-1:0]       be_n_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] sram_addr_d;

    logic wr_space, wbuf_empty, rd_ok, push, pop, rd_accept, rd_last;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign wr_space   = wbuf_count < DEPTH_C;
    assign wbuf_empty = wbuf_count == '0;
    assign rd_last    = (state == RD_WAIT) && (cnt == RD_LAST);

`ifdef SRAMCTL_RD_FWD_EN
    logic             fwd_match, fwd_full;
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_full  = 1'b0;
        fwd_data  = '0;
        idx       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < wbuf_count) && (fifo_addr[idx] == req_addr)) begin
                fwd_match = 1'b1;
                fwd_full  = &fifo_be[idx];
                fwd_data  = fifo_data[idx];
            end
        end
    end

    // A partial match must wait until the SRAM holds the merged value.
    assign rd_ok   = (state == IDLE) && (!fwd_match || fwd_full);
    assign fwd_hit = fwd_match;
`else
    assign rd_ok    = (state == IDLE) && wbuf_empty;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign req_ready = !rst && (req_write ? wr_space : rd_ok);
    assign push      = !rst && req_valid && req_write && wr_space && (|req_be);
    assign rd_accept = !rst && req_valid && !req_write && rd_ok;
    // A read accepted in IDLE wins the cycle; otherwise the head drains.
    assign pop       = (state == IDLE) && !wbuf_empty && !rd_accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (rd_accept && !fwd_hit) begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end else if (pop) begin
                    state_d = WR_PULSE;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                if (cnt == RD_LAST) state_d = IDLE;
                else                cnt_d   = cnt + 4'd1;
            end
            WR_PULSE: begin
                if (cnt == WE_LAST) begin
                    cnt_d   = '0;
                    state_d = (RECOVERY == 0) ? IDLE : WR_RECOV;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            WR_RECOV: begin
                if (cnt == REC_LAST) state_d = IDLE;
                else                 cnt_d   = cnt + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes are decoded from the next state and registered.
    always_comb begin
        wr_be_d     = pop ? fifo_be[rd_ptr] : wr_be;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        be_n_d      = '1;
        drv_en_d    = 1'b0;
        case (state_d)
            RD_WAIT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            WR_PULSE: begin
                ce_n_d   = 1'b0;
                we_n_d   = 1'b0;
                be_n_d   = ~wr_be_d;
                drv_en_d = 1'b1;
            end
            WR_RECOV: begin
                ce_n_d   = 1'b0;
                be_n_d   = ~wr_be_d;
                drv_en_d = 1'b1;
            end
            default: ;
        endcase

        sram_addr_d = sram_addr;
        if (pop)                        sram_addr_d = fifo_addr[rd_ptr];
        else if (rd_accept && !fwd_hit) sram_addr_d = req_addr;

        rsp_valid_d = rd_last || (rd_accept && fwd_hit);
        rsp_rdata_d = rsp_rdata;
        if (rd_last)                    rsp_rdata_d = sram_data;
        else if (rd_accept && fwd_hit)  rsp_rdata_d = fwd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
            sram_addr  <= '0;
            drv_en     <= 1'b0;
            wr_be      <= '0;
            wr_data    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            wbuf_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            sram_we_n <= we_n_d;
            sram_be_n <= be_n_d;
            sram_addr <= sram_addr_d;
            drv_en    <= drv_en_d;
            wr_be     <= wr_be_d;
            if (pop) wr_data <= fifo_data[rd_ptr];
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   wbuf_count <= wbuf_count + CNT_W'(1);
                2'b01:   wbuf_count <= wbuf_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Buffer payload needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_addr;
            fifo_be[wr_ptr]   <= req_be;
            fifo_data[wr_ptr] <= req_wdata;
        end
    end

    assign sram_data = drv_en ? wr_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_timing_ctrl.sv
module tb_sram_timing_ctrl;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int WE_W = 3;
    localparam int REC  = 2;
    localparam int RDW  = 1;

`ifdef SRAMCTL_RD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [2:0]    wbuf_count;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [BW-1:0] sram_be_n;

    sram_timing_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
        .WE_WIDTH(WE_W), .RECOVERY(REC), .READ_WAIT(RDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wbuf_count(wbuf_count),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM (low 8 address bits only).
    logic [DW-1:0] mem [0:255];
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : {DW{1'bz}};
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n)
            for (int b = 0; b < BW; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
    end

    int checks = 0;
    int errors = 0;
    int stall, lat, we_lo, rec_lo;
    logic [BW-1:0] be_cap;
    logic [AW-1:0] addr_cap;
    logic [2:0]    cnt_at_stall;
    logic [DW-1:0] rd_data, hold_data;
    logic          ce_l1, oe_l1, pulse_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_be = be; req_wdata = d;
        stall = 0; cnt_at_stall = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) break;
            stall++;
            cnt_at_stall = wbuf_count;
            @(posedge clk);
        end
        chk("wr_ready_bound", 32'(stall < 200), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_be = '0;
        stall = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) break;
            stall++;
            @(posedge clk);
        end
        chk("rd_ready_bound", 32'(stall < 200), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (lat == 1) begin ce_l1 = sram_ce_n; oe_l1 = sram_oe_n; end
            if (rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("rd_rsp_bound", 32'(rsp_valid), 1);
        rd_data = rsp_rdata;
        @(posedge clk); @(negedge clk);
        pulse_after = rsp_valid;
        hold_data   = rsp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!sram_we_n) begin we_lo++; be_cap = sram_be_n; addr_cap = sram_addr; end
            if (!sram_ce_n && sram_we_n && sram_oe_n) rec_lo++;
            if (wbuf_count == 0 && sram_ce_n) begin done = 1'b1; break; end
            @(posedge clk);
        end
        chk("drain_bound", 32'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        req_addr = '0; req_be = 4'hF; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_be_n", sram_be_n, 4'hF);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_count", wbuf_count, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_count", wbuf_count, 0);
        @(posedge clk); #1;

        // Basic write then read
        we_lo = 0; rec_lo = 0;
        do_write(20'h00010, 4'hF, 32'hDEADBEEF);
        chk("t1_count_after_accept", wbuf_count, 1);
        chk("t1_no_sram_at_accept", sram_ce_n, 1);
        wait_drain();
        chk("t1_we_low_cycles", we_lo, WE_W);
        chk("t1_recov_cycles", rec_lo, REC);
        chk("t1_be_n_pulse", be_cap, 4'h0);
        chk("t1_addr_pulse", addr_cap, 20'h00010);
        do_read(20'h00010);
        chk("t1_rd_stall", stall, 0);
        chk("t1_rd_latency", lat, RDW + 2);
        chk("t1_rd_oe_n", oe_l1, 0);
        chk("t1_rd_data", rd_data, 32'hDEADBEEF);
        chk("t1_rsp_one_pulse", pulse_after, 0);
        chk("t1_rdata_held", hold_data, 32'hDEADBEEF);

        // Zero byte-enable write is dropped
        do_write(20'h00010, 4'h0, 32'h0);
        chk("be0_count", wbuf_count, 0);
        @(negedge clk);
        chk("be0_no_sram", sram_ce_n, 1);
        @(posedge clk); #1;

        // Byte-lane write
        do_write(20'h00020, 4'hF, 32'h11223344);
        wait_drain();
        we_lo = 0;
        do_write(20'h00020, 4'b0010, 32'h0000AA00);
        wait_drain();
        chk("t2_be_n_pulse", be_cap, 4'b1101);
        do_read(20'h00020);
        chk("t2_rd_data", rd_data, 32'h1122AA44);

        // Buffer full: first entry drains immediately, the sixth push sees a full buffer
        for (int i = 0; i < 5; i++) do_write(20'h00040 + 20'(i), 4'hF, 32'hB0000000 + 32'(i));
        chk("t3_count_full", wbuf_count, 4);
        do_write(20'h00045, 4'hF, 32'hB0000005);
        chk("t3_full_stall", stall, 3);
        chk("t3_count_in_stall", cnt_at_stall, 4);
        chk("t3_count_after", wbuf_count, 4);
        wait_drain();
        do_read(20'h00045);
        chk("t3_rd_last", rd_data, 32'hB0000005);
        do_read(20'h00040);
        chk("t3_rd_first", rd_data, 32'hB0000000);

        // Read of a freshly buffered full write
        do_write(20'h00005, 4'hF, 32'hCAFEF00D);
        do_read(20'h00005);
        chk("t4_stall", stall, FWD ? 0 : 6);
        chk("t4_latency", lat, FWD ? 1 : RDW + 2);
        chk("t4_ce_n", ce_l1, FWD ? 1 : 0);
        chk("t4_data", rd_data, 32'hCAFEF00D);
        wait_drain();

        // Read to an unrelated address with a write buffered
        do_write(20'h00009, 4'hF, 32'h99999999);
        do_read(20'h00010);
        chk("byp_stall", stall, FWD ? 0 : 6);
        chk("byp_latency", lat, RDW + 2);
        chk("byp_data", rd_data, 32'hDEADBEEF);
        wait_drain();
        do_read(20'h00009);
        chk("byp_written", rd_data, 32'h99999999);

        // Partial-write hazard
        do_write(20'h00007, 4'hF, 32'h55667788);
        wait_drain();
        do_write(20'h00007, 4'b0001, 32'h000000AB);
        do_read(20'h00007);
        chk("t5_stall", stall, 6);
        chk("t5_latency", lat, RDW + 2);
        chk("t5_data", rd_data, 32'h556677AB);

        // Reset in the middle of a write pulse
        do_write(20'h00030, 4'hF, 32'h12345678);
        do_write(20'h00031, 4'hF, 32'h87654321);
        @(negedge clk);
        chk("t6_in_pulse", sram_we_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_we_n", sram_we_n, 1);
        chk("t6_ce_n", sram_ce_n, 1);
        chk("t6_oe_n", sram_oe_n, 1);
        chk("t6_be_n", sram_be_n, 4'hF);
        chk("t6_addr", sram_addr, 0);
        chk("t6_count", wbuf_count, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_rdata", rsp_rdata, 0);
        chk("t6_req_ready", req_ready, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_idle_after", sram_ce_n, 1);
        chk("t6_count_after", wbuf_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
